// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier, one accumulator step per clock.
// Signed operands are multiplied as magnitudes and the result is negated at the end.
module seq_multiplier #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CW    = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] product,
  output logic               rdy,
  output logic               busy,
  output logic [CW-1:0]      iter
);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  localparam logic [CW-1:0] IterLast = CW'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [2*WIDTH:0]   acc_q;
  logic [WIDTH-1:0]   mcand_q;
  logic               neg_q;
  logic [CW-1:0]      iter_q;
  logic [2*WIDTH-1:0] product_q;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     upper_sum;
  logic [2*WIDTH:0]   acc_step;

  // Operand magnitudes; the most negative value maps onto an unsigned 2^(WIDTH-1).
  always_comb begin
    mag_a = (signed_mode && multiplicand[WIDTH-1]) ? (~multiplicand + 1'b1) : multiplicand;
    mag_b = (signed_mode && multiplier[WIDTH-1])   ? (~multiplier + 1'b1)   : multiplier;
  end

  // One shift-add step: conditional add into the upper WIDTH+1 bits, then shift right.
  always_comb begin
    upper_sum = acc_q[2*WIDTH:WIDTH];
    if (acc_q[0]) begin
      upper_sum = acc_q[2*WIDTH:WIDTH] + {1'b0, mcand_q};
    end
    acc_step = {upper_sum, acc_q[WIDTH-1:0]} >> 1;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; run is only looked at in IDLE and DONE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (run) state_d = StCalc;
      StCalc:  if (iter_q == IterLast) state_d = StFix;
      StFix:   state_d = StDone;
      StDone:  if (!run) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath: capture operands, iterate, and publish the signed/unsigned result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      mcand_q   <= '0;
      neg_q     <= 1'b0;
      iter_q    <= '0;
      product_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (run) begin
            acc_q   <= {{(WIDTH + 1){1'b0}}, mag_b};
            mcand_q <= mag_a;
            neg_q   <= signed_mode & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
            iter_q  <= '0;
          end
        end
        StCalc: begin
          acc_q  <= acc_step;
          iter_q <= iter_q + 1'b1;
        end
        StFix: begin
          product_q <= neg_q ? (~acc_q[2*WIDTH-1:0] + 1'b1) : acc_q[2*WIDTH-1:0];
        end
        StDone: begin
          if (!run) iter_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign product = product_q;
  assign iter    = iter_q;
  assign rdy     = (state_q == StDone);
  assign busy    = (state_q == StCalc) || (state_q == StFix);

endmodule
